// File: rtl/pop_phase_sequencer.sv
// ============================================================================
// Module   : pop_phase_sequencer
// Function : Repeating pump/dark/probe/gap phase sequencer with down-counter
//            timing, abort, and a completed-repetition counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pop_phase_sequencer #(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WIDTH-1:0]  pump_len_i,
    input  logic [WIDTH-1:0]  dark_len_i,
    input  logic [WIDTH-1:0]  probe_len_i,
    input  logic [WIDTH-1:0]  gap_len_i,
    input  logic [CWIDTH-1:0] cycles_i,
    output logic              pump_out_o,
    output logic              probe_out_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        phase_o,
    output logic [CWIDTH-1:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUMP  = 3'd1,
        S_DARK  = 3'd2,
        S_PROBE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [CWIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [WIDTH-1:0]  pump_len_q, dark_len_q, probe_len_q, gap_len_q;
    logic [CWIDTH-1:0] cycles_q;
    logic              latch_en;
    logic [CWIDTH:0]   reps_next;
    logic              pump_q, probe_q, busy_q, done_q;

    // A zero-length phase still occupies one cycle, so 0 and 1 both load 0.
    function automatic logic [WIDTH-1:0] load_val(input logic [WIDTH-1:0] len);
        return (len == '0) ? '0 : len - WIDTH'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        latch_en    = 1'b0;
        reps_next   = {1'b0, cycle_cnt_q} + (CWIDTH+1)'(1);
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    latch_en    = 1'b1;
                    cycle_cnt_d = '0;
                    if (cycles_i == '0) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_PUMP;
                        cnt_d   = load_val(pump_len_i);
                    end
                end
            end
            S_PUMP: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_DARK;
                    cnt_d   = load_val(dark_len_q);
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            S_DARK: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_PROBE;
                    cnt_d   = load_val(probe_len_q);
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            S_PROBE: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = load_val(gap_len_q);
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            S_GAP: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    cycle_cnt_d = reps_next[CWIDTH-1:0];
                    if (reps_next < {1'b0, cycles_q}) begin
                        state_d = S_PUMP;
                        cnt_d   = load_val(pump_len_q);
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with phase_o.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cycle_cnt_q <= '0;
            pump_len_q  <= '0;
            dark_len_q  <= '0;
            probe_len_q <= '0;
            gap_len_q   <= '0;
            cycles_q    <= '0;
            pump_q      <= 1'b0;
            probe_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            if (latch_en) begin
                pump_len_q  <= pump_len_i;
                dark_len_q  <= dark_len_i;
                probe_len_q <= probe_len_i;
                gap_len_q   <= gap_len_i;
                cycles_q    <= cycles_i;
            end
            pump_q  <= (state_d == S_PUMP);
            probe_q <= (state_d == S_PROBE);
            busy_q  <= (state_d == S_PUMP) || (state_d == S_DARK) ||
                       (state_d == S_PROBE) || (state_d == S_GAP);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign pump_out_o  = pump_q;
    assign probe_out_o = probe_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign phase_o     = state_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pop_phase_sequencer.sv
// ============================================================================
// Module   : tb_pop_phase_sequencer
// Function : Directed self-checking bench for pop_phase_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pop_phase_sequencer;

    localparam int WIDTH  = 16;
    localparam int CWIDTH = 8;

    logic              clk;
    logic              reset;
    logic              start_i;
    logic              abort_i;
    logic [WIDTH-1:0]  pump_len_i, dark_len_i, probe_len_i, gap_len_i;
    logic [CWIDTH-1:0] cycles_i;
    logic              pump_out_o, probe_out_o, busy_o, done_o;
    logic [2:0]        phase_o;
    logic [CWIDTH-1:0] cycle_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    pop_phase_sequencer #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .pump_len_i  (pump_len_i),
        .dark_len_i  (dark_len_i),
        .probe_len_i (probe_len_i),
        .gap_len_i   (gap_len_i),
        .cycles_i    (cycles_i),
        .pump_out_o  (pump_out_o),
        .probe_out_o (probe_out_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .phase_o     (phase_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {phase, pump, probe, busy, done} for a given phase code.
    function automatic logic [6:0] outs_for(input logic [2:0] ph);
        return {ph, ph == 3'd1, ph == 3'd3, (ph >= 3'd1) && (ph <= 3'd4), ph == 3'd5};
    endfunction

    function automatic logic [6:0] obs();
        return {phase_o, pump_out_o, probe_out_o, busy_o, done_o};
    endfunction

    task automatic set_cfg(input int p, input int d, input int pr, input int g, input int c);
        pump_len_i  = WIDTH'(p);
        dark_len_i  = WIDTH'(d);
        probe_len_i = WIDTH'(pr);
        gap_len_i   = WIDTH'(g);
        cycles_i    = CWIDTH'(c);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b1; abort_i = 1'b0;
        set_cfg(5, 5, 5, 5, 5);
        step(); step(); step();
        n_cmp++; if (obs() !== 7'd0) begin n_err++; $display("FAIL reset_outs: got %b expected %b", obs(), 7'd0); end
        n_cmp++; if (cycle_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt_o); end
        reset = 1'b0; start_i = 1'b0;
        step();
        n_cmp++; if (obs() !== 7'd0) begin n_err++; $display("FAIL reset_idle: got %b expected %b", obs(), 7'd0); end
    endtask

    task automatic test_basic();
        logic [2:0] ep;
        set_cfg(3, 2, 4, 1, 2);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (k <= 20) begin
                int p;
                p  = (k - 1) % 10;
                ep = (p < 3) ? 3'd1 : (p < 5) ? 3'd2 : (p < 9) ? 3'd3 : 3'd4;
            end else begin
                ep = 3'd5;
            end
            n_cmp++;
            if (obs() !== outs_for(ep)) begin
                n_err++;
                $display("FAIL basic_cycle%0d: got %b expected %b", k, obs(), outs_for(ep));
            end
            if (k == 4)  set_cfg(9, 9, 9, 9, 9);
            if (k == 10) start_i = 1'b1;
            if (k == 11) start_i = 1'b0;
            step();
        end
        n_cmp++; if (obs() !== outs_for(3'd0)) begin n_err++; $display("FAIL basic_after: got %b expected %b", obs(), outs_for(3'd0)); end
        n_cmp++; if (cycle_cnt_o !== 8'd2) begin n_err++; $display("FAIL basic_cycle_cnt: got %0d expected 2", cycle_cnt_o); end
    endtask

    task automatic test_zero_lengths();
        set_cfg(0, 0, 0, 0, 1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            logic [2:0] ep;
            ep = (k <= 5) ? 3'(k) : 3'd0;
            n_cmp++;
            if (obs() !== outs_for(ep)) begin
                n_err++;
                $display("FAIL zero_len_cycle%0d: got %b expected %b", k, obs(), outs_for(ep));
            end
            step();
        end
        n_cmp++; if (cycle_cnt_o !== 8'd1) begin n_err++; $display("FAIL zero_len_cycle_cnt: got %0d expected 1", cycle_cnt_o); end
    endtask

    task automatic test_zero_cycles();
        set_cfg(5, 5, 5, 5, 0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        n_cmp++; if (obs() !== outs_for(3'd5)) begin n_err++; $display("FAIL zero_cyc_done: got %b expected %b", obs(), outs_for(3'd5)); end
        n_cmp++; if (cycle_cnt_o !== 8'd0) begin n_err++; $display("FAIL zero_cyc_cnt: got %0d expected 0", cycle_cnt_o); end
        step();
        n_cmp++; if (obs() !== outs_for(3'd0)) begin n_err++; $display("FAIL zero_cyc_idle: got %b expected %b", obs(), outs_for(3'd0)); end
    endtask

    task automatic test_abort();
        logic seen_done;
        set_cfg(1, 1, 2, 1, 3);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 1; k < 8; k++) step();
        n_cmp++; if (obs() !== outs_for(3'd3)) begin n_err++; $display("FAIL abort_pre_probe: got %b expected %b", obs(), outs_for(3'd3)); end
        n_cmp++; if (cycle_cnt_o !== 8'd1) begin n_err++; $display("FAIL abort_pre_cnt: got %0d expected 1", cycle_cnt_o); end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        n_cmp++; if (obs() !== outs_for(3'd0)) begin n_err++; $display("FAIL abort_idle: got %b expected %b", obs(), outs_for(3'd0)); end
        n_cmp++; if (cycle_cnt_o !== 8'd1) begin n_err++; $display("FAIL abort_cnt: got %0d expected 1", cycle_cnt_o); end
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            seen_done = seen_done | done_o;
            step();
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
        n_cmp++; if (phase_o !== 3'd0) begin n_err++; $display("FAIL abort_stays_idle: got %0d expected 0", phase_o); end
    endtask

    task automatic test_start_held();
        logic [2:0] tbl [8];
        tbl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        set_cfg(2, 1, 1, 1, 1);
        start_i = 1'b1;
        step();
        for (int k = 1; k <= 8; k++) begin
            n_cmp++;
            if (obs() !== outs_for(tbl[k-1])) begin
                n_err++;
                $display("FAIL held_cycle%0d: got %b expected %b", k, obs(), outs_for(tbl[k-1]));
            end
            if (k == 2) set_cfg(7, 7, 7, 7, 4);
            if (k == 6) begin
                n_cmp++; if (cycle_cnt_o !== 8'd1) begin n_err++; $display("FAIL held_done_cnt: got %0d expected 1", cycle_cnt_o); end
            end
            if (k == 8) begin
                n_cmp++; if (cycle_cnt_o !== 8'd0) begin n_err++; $display("FAIL held_restart_cnt: got %0d expected 0", cycle_cnt_o); end
            end
            if (k < 8) step();
        end
        start_i = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        n_cmp++; if (obs() !== outs_for(3'd0)) begin n_err++; $display("FAIL held_abort_pump: got %b expected %b", obs(), outs_for(3'd0)); end
    endtask

    task automatic test_reset_mid_dark();
        set_cfg(2, 5, 1, 1, 2);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 1; k < 12; k++) step();
        n_cmp++; if (phase_o !== 3'd2) begin n_err++; $display("FAIL rst_dark_phase: got %0d expected 2", phase_o); end
        n_cmp++; if (cycle_cnt_o !== 8'd1) begin n_err++; $display("FAIL rst_dark_cnt: got %0d expected 1", cycle_cnt_o); end
        reset = 1'b1; start_i = 1'b1; abort_i = 1'b1;
        step();
        n_cmp++; if (obs() !== 7'd0) begin n_err++; $display("FAIL rst_dark_outs: got %b expected %b", obs(), 7'd0); end
        n_cmp++; if (cycle_cnt_o !== 8'd0) begin n_err++; $display("FAIL rst_dark_cycle_cnt: got %0d expected 0", cycle_cnt_o); end
        reset = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        step();
        n_cmp++; if (obs() !== 7'd0) begin n_err++; $display("FAIL rst_dark_post: got %b expected %b", obs(), 7'd0); end
    endtask

    task automatic test_start_abort_idle();
        set_cfg(1, 1, 1, 1, 1);
        start_i = 1'b1; abort_i = 1'b1;
        step();
        n_cmp++; if (obs() !== outs_for(3'd0)) begin n_err++; $display("FAIL start_abort_idle: got %b expected %b", obs(), outs_for(3'd0)); end
        start_i = 1'b0; abort_i = 1'b0;
        step();
        n_cmp++; if (obs() !== outs_for(3'd0)) begin n_err++; $display("FAIL start_abort_after: got %b expected %b", obs(), outs_for(3'd0)); end
    endtask

    task automatic test_max();
        int cnt;
        set_cfg(65535, 0, 0, 0, 1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        cnt = 0;
        while (pump_out_o && cnt < 70000) begin
            cnt++;
            step();
        end
        n_cmp++; if (cnt != 65535) begin n_err++; $display("FAIL max_pump_len: got %0d expected 65535", cnt); end
        n_cmp++; if (phase_o !== 3'd2) begin n_err++; $display("FAIL max_next_phase: got %0d expected 2", phase_o); end
        for (int k = 0; k < 4; k++) step();
        n_cmp++; if (obs() !== outs_for(3'd0)) begin n_err++; $display("FAIL max_end_idle: got %b expected %b", obs(), outs_for(3'd0)); end
        n_cmp++; if (cycle_cnt_o !== 8'd1) begin n_err++; $display("FAIL max_cycle_cnt: got %0d expected 1", cycle_cnt_o); end
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_zero_lengths();
        test_zero_cycles();
        test_abort();
        test_start_held();
        test_reset_mid_dark();
        test_start_abort_idle();
        test_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
